// File: rtl/acc_datapath_pkg.sv
// acc_datapath_pkg: select encodings and default width shared by the accumulator datapath.
package acc_datapath_pkg;
    localparam int DATA_W_DEF = 4;
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;
    localparam logic [1:0] SEL_COPY = 2'b11;
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational ALU for the accumulator; priority add > sub > and > mul > div.
module acc_alu
    import acc_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] h_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              l0_i,
    input  logic              c_i,
    input  logic              add_i,
    input  logic              sub_i,
    input  logic              and_i,
    input  logic              mul_i,
    input  logic              div_i,
    output logic [DATA_W-1:0] r_o,
    output logic              co_o,
    output logic              q_o,
    output logic              q_en_o
);
    logic [DATA_W:0] sum_add, sum_sub, sum_mul;

    assign sum_add = {1'b0, h_i} + {1'b0, b_i};
    assign sum_sub = {1'b0, h_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
    assign sum_mul = {1'b0, h_i} + {1'b0, l0_i ? b_i : '0};
    assign q_o     = h_i >= b_i;
    // Restoring divide only writes the quotient bit when no higher-priority op is active.
    assign q_en_o  = div_i & ~(add_i | sub_i | and_i | mul_i);

    always_comb begin
        {co_o, r_o} = add_i ? sum_add :
                      sub_i ? sum_sub :
                      and_i ? {c_i, h_i & b_i} :
                      mul_i ? sum_mul :
                      (div_i && q_o) ? {c_i, h_i - b_i} : {c_i, h_i};
    end
endmodule

// File: rtl/acc_datapath.sv
// acc_datapath: accumulator high/low halves plus carry, executing control strobes each clock.
module acc_datapath
    import acc_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic [DATA_W-1:0] bus_data,
    input  logic [DATA_W-1:0] breg_data,
    input  logic [1:0]        acc_high_select_in,
    input  logic [1:0]        acc_low_select,
    input  logic              acc_in_select,
    input  logic              acc_high_reset_p,
    input  logic              acc_o_en,
    input  logic              op_add,
    input  logic              op_sub,
    input  logic              op_and,
    input  logic              op_mul,
    input  logic              op_div,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic [DATA_W-1:0] acc_high_data,
    output logic [DATA_W-1:0] acc_low_data,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              sign_flag
);
    logic [DATA_W-1:0] h_q, h_d, l_q, l_d, r;
    logic              c_q, c_d, co, q, q_en;

    acc_alu #(.DATA_W(DATA_W)) u_alu (
        .h_i   (h_q),
        .b_i   (breg_data),
        .l0_i  (l_q[0]),
        .c_i   (c_q),
        .add_i (op_add),
        .sub_i (op_sub),
        .and_i (op_and),
        .mul_i (op_mul),
        .div_i (op_div),
        .r_o   (r),
        .co_o  (co),
        .q_o   (q),
        .q_en_o(q_en)
    );

    always_comb begin
        h_d = h_q;
        c_d = c_q;
        if (acc_high_reset_p) begin
            h_d = '0;
            c_d = 1'b0;
        end else if (acc_high_select_in == SEL_SHR) begin
            h_d = {c_q, h_q[DATA_W-1:1]};
            c_d = 1'b0;
        end else if (acc_high_select_in == SEL_SHL) begin
            h_d = {h_q[DATA_W-2:0], l_q[DATA_W-1]};
        end else if (acc_high_select_in == SEL_LOAD) begin
            h_d = acc_in_select ? bus_data : r;
            c_d = acc_in_select ? c_q : co;
        end
    end

    // The low half chains under the high half only when both shift right together.
    always_comb begin
        l_d = l_q;
        if (acc_low_select == SEL_SHR)
            l_d = {(acc_high_select_in == SEL_SHR) & h_q[0], l_q[DATA_W-1:1]};
        else if (acc_low_select == SEL_SHL)
            l_d = {l_q[DATA_W-2:0], 1'b0};
        else if (acc_low_select == SEL_COPY)
            l_d = h_q;
        else if (q_en)
            l_d[0] = q;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            h_q <= '0;
            l_q <= '0;
            c_q <= 1'b0;
        end else begin
            h_q <= h_d;
            l_q <= l_d;
            c_q <= c_d;
        end
    end

    assign bus_out       = acc_o_en ? h_q : '0;
    assign bus_oe        = acc_o_en;
    assign acc_high_data = h_q;
    assign acc_low_data  = l_q;
    assign carry_flag    = c_q;
    assign zero_flag     = h_q == '0;
    assign sign_flag     = h_q[DATA_W-1];
endmodule
